// File: rtl/ifb_pkg.sv
// Shared definitions for the instruction prefetch buffer.
//   NOP_INSTR : instruction presented when no entry is valid, and pushed for a misaligned fetch.
//   state_e   : fetch FSM state (idle / waiting for response / dropping a stale response).
//   entry_t   : FIFO entry layout {instr[15:0], pc_next[15:0], err}, 33 bits.
package ifb_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrop
  } state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_next;
    logic        err;
  } entry_t;

endpackage

// File: rtl/ifetch_buffer_if.sv
// Instruction memory bus between the prefetch unit and the instruction memory.
//   mem_req/mem_addr : request strobe and address, held until accepted (mem_stall low).
//   mem_stall        : memory cannot accept this cycle.
//   mem_done         : one-cycle response strobe; mem_rdata and mem_err valid with it.
// Modports: master = prefetch unit, slave = memory.
interface ifetch_buffer_if;

  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_stall;
  logic        mem_done;
  logic [15:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_stall,
    input  mem_done,
    input  mem_rdata,
    input  mem_err
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_stall,
    output mem_done,
    output mem_rdata,
    output mem_err
  );

endinterface

// File: rtl/ifb_fifo.sv
// Circular buffer of fetched instructions.
//   clk, rst (sync, active-low), flush : clear all entries.
//   push/push_data                     : write one entry at the tail (ignored when full).
//   pop                                : drop the head entry (ignored when empty).
//   head                               : current head entry, valid when !empty.
//   empty/full                         : occupancy flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ifb_fifo
  import ifb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   empty,
  output logic   full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  entry_t      mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

  // Storage needs no reset: entries are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction prefetch unit: issues one-outstanding sequential fetches to a stallable,
// multi-cycle instruction memory and buffers returned instructions for the IF/ID latch.
//   clk, rst (sync, active-low)
//   redirect/redirect_pc : flush the buffer and restart fetching at redirect_pc.
//   deq                  : IF/ID latch consumes the head entry when out_valid.
//   out_valid/out_instr/out_pc_next/out_err : head entry (NOP/0/0 when empty).
//   mem                  : instruction memory bus (master side).
// Optional feature macro: IFB_BYPASS_EN -- forward a response straight to out_* when the
// buffer is empty.
module ifetch_buffer
  import ifb_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [15:0]           redirect_pc,
  input  logic                  deq,
  output logic                  out_valid,
  output logic [15:0]           out_instr,
  output logic [15:0]           out_pc_next,
  output logic                  out_err,
  ifetch_buffer_if.master       mem
);

  state_e      state_q;
  logic [15:0] fetch_pc_q;
  logic        halted_q;

  logic        fifo_empty;
  logic        fifo_full;
  entry_t      head;
  entry_t      push_data;
  logic        push;
  logic        pop;
  logic        can_issue;
  logic        misalign;
  logic        accept;
  logic        resp_ok;

  // Issue only in IDLE, so the free slot checked here is the one reserved for the request.
  assign can_issue = rst && (state_q == StIdle) && !halted_q && !redirect && !fifo_full;
  assign misalign  = can_issue && fetch_pc_q[0];
  assign mem.mem_req  = can_issue && !fetch_pc_q[0];
  assign mem.mem_addr = mem.mem_req ? fetch_pc_q : 16'h0000;
  assign accept       = mem.mem_req && !mem.mem_stall;

  assign resp_ok = rst && (state_q == StWait) && mem.mem_done && !redirect;

  // fetch_pc_q already advanced at accept, so it equals the request PC + 2.
  always_comb begin
    push_data = '{instr: mem.mem_rdata, pc_next: fetch_pc_q, err: mem.mem_err};
    if (misalign) push_data = '{instr: NOP_INSTR, pc_next: fetch_pc_q + 16'd2, err: 1'b1};
  end

`ifdef IFB_BYPASS_EN
  logic bypass;
  assign bypass = resp_ok && fifo_empty;
  // A bypassed instruction consumed in the same cycle never enters the buffer.
  assign push   = misalign || (resp_ok && !(bypass && deq));
`else
  assign push   = misalign || resp_ok;
`endif
  assign pop = deq && !fifo_empty;

  ifb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    out_valid   = !fifo_empty;
    out_instr   = head.instr;
    out_pc_next = head.pc_next;
    out_err     = head.err;
`ifdef IFB_BYPASS_EN
    if (bypass) begin
      out_valid   = 1'b1;
      out_instr   = mem.mem_rdata;
      out_pc_next = fetch_pc_q;
      out_err     = mem.mem_err;
    end
`endif
    if (!out_valid) begin
      out_instr   = NOP_INSTR;
      out_pc_next = 16'h0000;
      out_err     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      halted_q   <= 1'b0;
    end else if (redirect) begin
      fetch_pc_q <= redirect_pc;
      halted_q   <= 1'b0;
      // A response still owed by memory must be swallowed before fetching again.
      state_q    <= (state_q != StIdle && !mem.mem_done) ? StDrop : StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q    <= StWait;
            fetch_pc_q <= fetch_pc_q + 16'd2;
          end else if (misalign) begin
            halted_q <= 1'b1;
          end
        end
        StWait: begin
          if (mem.mem_done) begin
            state_q <= StIdle;
            if (mem.mem_err) halted_q <= 1'b1;
          end
        end
        StDrop: begin
          if (mem.mem_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
